// File: rtl/spi_slave_core.sv
// spi_slave_core: SPI responder in the clk domain; oversampled pins, any CPOL/CPHA,
// REG_WIDTH-bit MSB-first words with a valid/ready tx holding register.
module spi_slave_core #(
    parameter int                   REG_WIDTH = 16,
    parameter bit                   CPOL      = 1'b1,
    parameter bit                   CPHA      = 1'b1,
    parameter logic [REG_WIDTH-1:0] FILL_WORD = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SPI_CS_N,
    input  logic                 SPI_SCLK,
    input  logic                 SPI_MOSI,
    output logic                 SPI_MISO,
    output logic                 SPI_MISO_OE,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [REG_WIDTH-1:0] tx_data,
    output logic                 rx_valid,
    output logic [REG_WIDTH-1:0] rx_data,
    output logic                 rx_err,
    output logic                 tx_underrun
);
    localparam int CW = $clog2(REG_WIDTH + 1);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;
    logic [2:0] sclk_q, cs_q;
    logic [1:0] mosi_q, settle_q;
    logic armed_q;
    state_t state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [REG_WIDTH-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic [REG_WIDTH-1:0] hold_q, hold_d, rx_data_q, rx_data_d;
    logic full_q, full_d, rx_valid_q, rx_valid_d, rx_err_q, rx_err_d, tx_underrun_q, tx_underrun_d;
    logic sclk_chg, lead, trail, sample_e, shift_e, cs_fall, cs_rise, accept, load;
    // A CS_N already low when reset releases must not start a frame: arm only after a synced high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q   <= {3{CPOL}};
            cs_q     <= 3'b111;
            mosi_q   <= '0;
            settle_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            sclk_q   <= {sclk_q[1:0], SPI_SCLK};
            cs_q     <= {cs_q[1:0], SPI_CS_N};
            mosi_q   <= {mosi_q[0], SPI_MOSI};
            settle_q <= (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
            armed_q  <= armed_q | ((settle_q == 2'd3) & cs_q[1]);
        end
    end
    assign sclk_chg = sclk_q[1] ^ sclk_q[2];
    assign lead     = ~cs_q[1] & sclk_chg & (sclk_q[1] != CPOL);
    assign trail    = ~cs_q[1] & sclk_chg & (sclk_q[1] == CPOL);
    assign sample_e = CPHA ? trail : lead;
    assign shift_e  = CPHA ? lead : trail;
    assign cs_fall  = armed_q & cs_q[2] & ~cs_q[1];
    assign cs_rise  = cs_q[1] & ~cs_q[2];
    assign accept   = tx_valid & ~full_q;
    assign load     = state_q == S_LOAD;
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        rx_err_d      = 1'b0;
        tx_underrun_d = 1'b0;
        hold_d        = accept ? tx_data : hold_q;
        full_d        = load ? accept : (full_q | accept);
        case (state_q)
            S_IDLE: state_d = cs_fall ? S_LOAD : S_IDLE;
            S_LOAD: begin
                tx_shift_d    = full_q ? hold_q : FILL_WORD;
                tx_underrun_d = ~full_q;
                bit_cnt_d     = '0;
                state_d       = cs_rise ? S_IDLE : S_SHIFT;
            end
            S_SHIFT: begin
                if (cs_rise) begin
                    state_d  = S_IDLE;
                    rx_err_d = bit_cnt_q != '0;
                end else if (sample_e) begin
                    rx_shift_d = {rx_shift_q[REG_WIDTH-2:0], mosi_q[1]};
                    bit_cnt_d  = bit_cnt_q + CW'(1);
                    state_d    = (bit_cnt_q == CW'(REG_WIDTH - 1)) ? S_DONE : S_SHIFT;
                end else if (shift_e && bit_cnt_q != '0) begin
                    // bit_cnt==0 marks the first shift edge of a word (CPHA=1) or the
                    // trailing edge left over from the previous word (CPHA=0): keep the MSB.
                    tx_shift_d = tx_shift_q << 1;
                end
            end
            S_DONE: begin
                rx_data_d  = rx_shift_q;
                rx_valid_d = 1'b1;
                state_d    = cs_rise ? S_IDLE : S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            hold_q        <= '0;
            full_q        <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_err_q      <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            hold_q        <= hold_d;
            full_q        <= full_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_err_q      <= rx_err_d;
            tx_underrun_q <= tx_underrun_d;
        end
    end
    assign SPI_MISO    = tx_shift_q[REG_WIDTH-1];
    assign SPI_MISO_OE = state_q != S_IDLE;
    assign tx_ready    = ~full_q;
    assign rx_valid    = rx_valid_q;
    assign rx_data     = rx_data_q;
    assign rx_err      = rx_err_q;
    assign tx_underrun = tx_underrun_q;
endmodule
